// File: rtl/core_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem reads, buffers returned words
// and presents {fetch_pc, fetch_pc4, inst} to decode; handles stall, redirect and fetch faults.
module core_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] fetch_pc,
  output logic [63:0] fetch_pc4,
  output logic        fetch_fault
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] MAXO_C  = CNT_W'(MAX_OUTST);

  typedef enum logic {S_RUN, S_FAULT} state_t;

  state_t           state;
  logic [63:0]      req_pc, resp_pc, last_pc, last_pc4;
  logic [CNT_W-1:0] count, outstanding, discard, out_next;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             redirect_q;
  logic [63:0]      fifo_pc   [BUF_DEPTH];
  logic [31:0]      fifo_word [BUF_DEPTH];

  logic             fault, head_ok, pop, issue, ret, push, misaligned;
  logic [CNT_W:0]   occ;

  assign imem_addr = req_pc;

  // Space check credits this cycle's pop so a depth-2 buffer sustains one inst per cycle.
  always_comb begin
    fault      = (state == S_FAULT);
    head_ok    = !fault && (count != '0) && !redirect_q;
    inst_valid = fault || head_ok;
    pop        = head_ok && !stall && !redirect;
    occ        = {1'b0, count} + {1'b0, outstanding} - {{CNT_W{1'b0}}, pop};
    imem_req   = reset_n && !fault && !redirect && (outstanding < MAXO_C) &&
                 (occ < {1'b0, DEPTH_C});
    issue      = imem_req && imem_gnt;
    ret        = imem_rvalid && (outstanding != '0);
    push       = ret && (discard == '0) && !fault && !redirect;
    out_next   = outstanding + CNT_W'(issue) - CNT_W'(ret);
    misaligned = (redirect_pc[1:0] != 2'b00);
    fetch_pc    = head_ok ? fifo_pc[rd_ptr] : last_pc;
    fetch_pc4   = head_ok ? fifo_pc[rd_ptr] + 64'd4 : last_pc4;
    inst        = head_ok ? fifo_word[rd_ptr] : '0;
    fetch_fault = fault;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_RUN;
      req_pc      <= RESET_PC;
      resp_pc     <= RESET_PC;
      last_pc     <= '0;
      last_pc4    <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      redirect_q  <= 1'b0;
    end else begin
      outstanding <= out_next;
      redirect_q  <= redirect;
      if (redirect && misaligned) begin
        last_pc  <= redirect_pc;
        last_pc4 <= redirect_pc + 64'd4;
      end else begin
        last_pc  <= fetch_pc;
        last_pc4 <= fetch_pc4;
      end
      if (redirect) begin
        // Everything still in flight after this cycle's accounting is wrong-path.
        state   <= misaligned ? S_FAULT : S_RUN;
        count   <= '0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        discard <= out_next;
        req_pc  <= redirect_pc;
        resp_pc <= redirect_pc;
      end else begin
        count   <= count + CNT_W'(push) - CNT_W'(pop);
        rd_ptr  <= rd_ptr + PTR_W'(pop);
        wr_ptr  <= wr_ptr + PTR_W'(push);
        discard <= discard - CNT_W'(ret && (discard != '0));
        if (issue) req_pc  <= req_pc + 64'd4;
        if (push)  resp_pc <= resp_pc + 64'd4;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= resp_pc;
      fifo_word[wr_ptr] <= imem_rdata;
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && (count == DEPTH_C)));

endmodule

// File: tb/tb_core_fetch_unit.sv
// Directed and randomized checks of core_fetch_unit against an in-order memory model
// and a sequential-PC decode model.
module tb_core_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] fetch_pc;
  logic [63:0] fetch_pc4;
  logic        fetch_fault;

  int total = 0;
  int bad = 0;

  int unsigned cyc = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  bit          gnt_rand = 1'b0;

  typedef struct {
    logic [63:0] addr;
    int unsigned due;
  } pend_t;
  pend_t pend[$];
  pend_t pe;

  core_fetch_unit #(
    .RESET_PC (64'h0),
    .BUF_DEPTH(2),
    .MAX_OUTST(2)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .fetch_pc   (fetch_pc),
    .fetch_pc4  (fetch_pc4),
    .fetch_fault(fetch_fault)
  );

  always #5 clock = ~clock;

  // In-order memory: returns addr[31:0] lat cycles after the grant.
  always @(posedge clock) begin
    cyc++;
    if (!reset_n) pend.delete();
    else if (imem_req && imem_gnt) begin
      pe.addr = imem_addr;
      pe.due  = cyc + $urandom_range(lat_max, lat_min);
      pend.push_back(pe);
    end
    #1;
    if (reset_n && pend.size() > 0 && pend[0].due <= cyc + 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend[0].addr[31:0];
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    imem_gnt = gnt_rand ? 1'($urandom_range(1, 0)) : 1'b1;
  end

  task automatic do_reset();
    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got=%0h want=0", imem_req); end
    total++; if (imem_addr !== 64'h0) begin bad++; $display("FAIL rst_addr: got=%0h want=0", imem_addr); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got=%0h want=0", inst_valid); end
    total++; if (inst !== 32'h0) begin bad++; $display("FAIL rst_inst: got=%0h want=0", inst); end
    total++; if (fetch_pc !== 64'h0 || fetch_pc4 !== 64'h0) begin
      bad++; $display("FAIL rst_pc: got=%0h/%0h want=0/0", fetch_pc, fetch_pc4);
    end
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL rst_fault: got=%0h want=0", fetch_fault); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] want;
    lat_min = 1; lat_max = 1;
    do_reset();
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      bad++; $display("FAIL b2b_first_req: got=%0h@%0h want=1@0", imem_req, imem_addr);
    end
    for (int k = 1; k < 8; k++) begin
      @(posedge clock); #2;
      want = 64'(4 * k);
      total++; if (imem_req !== 1'b1 || imem_addr !== want) begin
        bad++; $display("FAIL b2b_req c%0d: got=%0h@%0h want=1@%0h", k, imem_req, imem_addr, want);
      end
      if (k < 2) begin
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL b2b_early_valid c%0d: got=%0h want=0", k, inst_valid); end
      end else begin
        want = 64'(4 * (k - 2));
        total++; if (inst_valid !== 1'b1 || fetch_pc !== want || inst !== want[31:0] || fetch_pc4 !== want + 64'd4) begin
          bad++; $display("FAIL b2b_inst c%0d: got v=%0h pc=%0h i=%0h pc4=%0h want pc=%0h", k, inst_valid, fetch_pc, inst, fetch_pc4, want);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] want;
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (2) @(posedge clock);
    #1 stall = 1'b1;
    #1;
    total++; if (inst_valid !== 1'b1 || fetch_pc !== 64'h0 || imem_req !== 1'b0) begin
      bad++; $display("FAIL stall_enter: got v=%0h pc=%0h req=%0h want 1/0/0", inst_valid, fetch_pc, imem_req);
    end
    for (int k = 3; k < 7; k++) begin
      @(posedge clock); #2;
      total++; if (imem_req !== 1'b0 || inst_valid !== 1'b1 || fetch_pc !== 64'h0) begin
        bad++; $display("FAIL stall_hold c%0d: got req=%0h v=%0h pc=%0h want 0/1/0", k, imem_req, inst_valid, fetch_pc);
      end
    end
    @(posedge clock);
    #1 stall = 1'b0;
    #1;
    total++; if (fetch_pc !== 64'h0 || imem_req !== 1'b1 || imem_addr !== 64'h8) begin
      bad++; $display("FAIL stall_release: got pc=%0h req=%0h addr=%0h want 0/1/8", fetch_pc, imem_req, imem_addr);
    end
    for (int k = 8; k < 11; k++) begin
      @(posedge clock); #2;
      want = 64'(4 * (k - 7));
      total++; if (inst_valid !== 1'b1 || fetch_pc !== want || inst !== want[31:0]) begin
        bad++; $display("FAIL stall_order c%0d: got v=%0h pc=%0h i=%0h want pc=%0h", k, inst_valid, fetch_pc, inst, want);
      end
    end
  endtask

  task automatic test_redirect();
    logic [63:0] want;
    int n;
    lat_min = 3; lat_max = 3;
    do_reset();
    repeat (2) @(posedge clock);
    #1 begin redirect = 1'b1; redirect_pc = 64'h1000; end
    #1;
    total++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      bad++; $display("FAIL redir_cycle: got req=%0h v=%0h want 0/0", imem_req, inst_valid);
    end
    @(posedge clock);
    #1 redirect = 1'b0;
    #1;
    total++; if (inst_valid !== 1'b0 || imem_addr !== 64'h1000) begin
      bad++; $display("FAIL redir_after: got v=%0h addr=%0h want 0/1000", inst_valid, imem_addr);
    end
    want = 64'h1000;
    n = 0;
    for (int i = 0; i < 30 && n < 3; i++) begin
      @(posedge clock); #2;
      if (inst_valid) begin
        total++; if (fetch_pc !== want || inst !== want[31:0]) begin
          bad++; $display("FAIL redir_stream: got pc=%0h i=%0h want %0h", fetch_pc, inst, want);
        end
        want += 64'd4;
        n++;
      end
    end
    total++; if (n != 3) begin bad++; $display("FAIL redir_timeout: got=%0d insts want=3", n); end
    lat_min = 1; lat_max = 1;
  endtask

  task automatic test_fault();
    int n;
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (4) @(posedge clock);
    #1 begin redirect = 1'b1; redirect_pc = 64'h1002; end
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL fault_redir_req: got=%0h want=0", imem_req); end
    @(posedge clock);
    #1 begin redirect = 1'b0; stall = 1'b1; end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin @(posedge clock); #1; end
      #1;
      total++; if (fetch_fault !== 1'b1 || inst_valid !== 1'b1 || inst !== 32'h0 || imem_req !== 1'b0) begin
        bad++; $display("FAIL fault_hold %0d: got f=%0h v=%0h i=%0h req=%0h want 1/1/0/0", k, fetch_fault, inst_valid, inst, imem_req);
      end
      total++; if (fetch_pc !== 64'h1002 || fetch_pc4 !== 64'h1006) begin
        bad++; $display("FAIL fault_pc %0d: got %0h/%0h want 1002/1006", k, fetch_pc, fetch_pc4);
      end
    end
    @(posedge clock);
    #1 begin stall = 1'b0; redirect = 1'b1; redirect_pc = 64'h3001; end
    @(posedge clock);
    #1 redirect = 1'b0;
    #1;
    total++; if (fetch_fault !== 1'b1 || fetch_pc !== 64'h3001) begin
      bad++; $display("FAIL fault_refault: got f=%0h pc=%0h want 1/3001", fetch_fault, fetch_pc);
    end
    @(posedge clock);
    #1 begin redirect = 1'b1; redirect_pc = 64'h2000; end
    @(posedge clock);
    #1 redirect = 1'b0;
    #1;
    total++; if (fetch_fault !== 1'b0 || inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h2000) begin
      bad++; $display("FAIL fault_exit: got f=%0h v=%0h req=%0h addr=%0h want 0/0/1/2000", fetch_fault, inst_valid, imem_req, imem_addr);
    end
    n = 0;
    for (int i = 0; i < 20 && n == 0; i++) begin
      @(posedge clock); #2;
      if (inst_valid) begin
        n++;
        total++; if (fetch_pc !== 64'h2000 || inst !== 32'h2000 || fetch_fault !== 1'b0) begin
          bad++; $display("FAIL fault_resume: got pc=%0h i=%0h f=%0h want 2000/2000/0", fetch_pc, inst, fetch_fault);
        end
      end
    end
    total++; if (n == 0) begin bad++; $display("FAIL fault_resume_timeout: got=0 insts want=1"); end
  endtask

  task automatic test_reset_midop();
    int n;
    lat_min = 2; lat_max = 2;
    do_reset();
    repeat (3) @(posedge clock);
    #4 reset_n = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || fetch_fault !== 1'b0) begin
      bad++; $display("FAIL midrst_ctl: got req=%0h v=%0h i=%0h f=%0h want 0/0/0/0", imem_req, inst_valid, inst, fetch_fault);
    end
    total++; if (imem_addr !== 64'h0 || fetch_pc !== 64'h0 || fetch_pc4 !== 64'h0) begin
      bad++; $display("FAIL midrst_pc: got addr=%0h pc=%0h pc4=%0h want 0/0/0", imem_addr, fetch_pc, fetch_pc4);
    end
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      bad++; $display("FAIL midrst_first_req: got %0h@%0h want 1@0", imem_req, imem_addr);
    end
    n = 0;
    for (int i = 0; i < 20 && n == 0; i++) begin
      @(posedge clock); #2;
      if (inst_valid) begin
        n++;
        total++; if (fetch_pc !== 64'h0 || inst !== 32'h0) begin
          bad++; $display("FAIL midrst_first_inst: got pc=%0h i=%0h want 0/0", fetch_pc, inst);
        end
      end
    end
    total++; if (n == 0) begin bad++; $display("FAIL midrst_timeout: got=0 insts want=1"); end
    lat_min = 1; lat_max = 1;
  endtask

  task automatic test_random();
    logic [63:0] exp_pc, fault_pc;
    bit          exp_fault, prev_redir;
    int unsigned r;
    int          accepted;
    lat_min = 1; lat_max = 4; gnt_rand = 1'b1;
    do_reset();
    exp_pc = 64'h0; fault_pc = 64'h0; exp_fault = 1'b0; prev_redir = 1'b0; accepted = 0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clock);
      #1;
      stall = ($urandom_range(3, 0) == 0);
      r = $urandom_range(99, 0);
      redirect = (r < 3);
      if (redirect) begin
        redirect_pc = {$urandom, $urandom} & ~64'h3;
        if (r == 0) redirect_pc[1:0] = 2'($urandom_range(3, 1));
      end
      #1;
      if (prev_redir && !exp_fault) begin
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rnd_post_redir_valid c%0d: got=%0h want=0", i, inst_valid); end
      end
      total++; if (fetch_fault !== exp_fault) begin
        bad++; $display("FAIL rnd_fault c%0d: got=%0h want=%0h", i, fetch_fault, exp_fault);
      end
      if (exp_fault) begin
        total++; if (inst_valid !== 1'b1 || fetch_pc !== fault_pc || inst !== 32'h0) begin
          bad++; $display("FAIL rnd_fault_out c%0d: got v=%0h pc=%0h i=%0h want 1/%0h/0", i, inst_valid, fetch_pc, inst, fault_pc);
        end
      end else if (inst_valid) begin
        total++; if (fetch_pc !== exp_pc || inst !== exp_pc[31:0] || fetch_pc4 !== exp_pc + 64'd4) begin
          bad++; $display("FAIL rnd_stream c%0d: got pc=%0h i=%0h pc4=%0h want pc=%0h", i, fetch_pc, inst, fetch_pc4, exp_pc);
        end
        if (!stall && !redirect) begin
          exp_pc += 64'd4;
          accepted++;
        end
      end
      if (redirect) begin
        if (redirect_pc[1:0] != 2'b00) begin
          exp_fault = 1'b1;
          fault_pc  = redirect_pc;
        end else begin
          exp_fault = 1'b0;
          exp_pc    = redirect_pc;
        end
      end
      prev_redir = redirect;
    end
    #1 begin redirect = 1'b0; stall = 1'b0; end
    total++; if (accepted < 500) begin bad++; $display("FAIL rnd_progress: got=%0d accepted want>=500", accepted); end
    gnt_rand = 1'b0; lat_min = 1; lat_max = 1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_redirect();
    test_fault();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
